// File: rtl/router_fifo.sv
// -----------------------------------------------------------------------------
// router_fifo
//
// Per-destination output buffer of the 1x3 router. Stores bytes from the
// register stage, tagging each packet header with lfd_state_i, and presents
// them to the destination on request. The read side tracks how many bytes of
// the current packet remain so that data_out_o can be released (high-Z) once a
// packet has been fully delivered and the port goes idle.
//
// Ports:
//   clk_i         - clock, all state updates on the rising edge
//   reset_i       - asynchronous active-high reset, clears all state at once
//   soft_reset_i  - synchronous active-high flush (destination timeout)
//   write_enb_i   - write request, accepted when not full
//   read_enb_i    - read request, accepted when not empty
//   lfd_state_i   - marks the byte written this cycle as a packet header
//   data_in_i     - byte to store
//   data_out_o    - registered read data, high-Z when no packet is in progress
//   full_o        - FIFO holds DEPTH entries
//   empty_o       - FIFO holds no entries
// -----------------------------------------------------------------------------
module router_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             soft_reset_i,
   input  logic             write_enb_i,
   input  logic             read_enb_i,
   input  logic             lfd_state_i,
   input  logic [WIDTH-1:0] data_in_i,
   output logic [WIDTH-1:0] data_out_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AddrW = $clog2(DEPTH);
   localparam int unsigned PtrW  = AddrW + 1;

   // Storage: data bits are never cleared, only the header tags are.
   logic [WIDTH-1:0] mem_data_q [DEPTH];
   logic [DEPTH-1:0] mem_tag_q, mem_tag_d;

   // Pointers carry an extra wrap bit to tell full from empty.
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [6:0]      pkt_cnt_q, pkt_cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic            oe_q, oe_d;

   logic [AddrW-1:0] wr_idx, rd_idx;
   logic             wr_acc, rd_acc;
   logic             rd_tag;
   logic [WIDTH-1:0] rd_data;

   assign wr_idx = wr_ptr_q[AddrW-1:0];
   assign rd_idx = rd_ptr_q[AddrW-1:0];

   // Flags come straight from the registered pointers, so a simultaneous
   // read and write is judged against the occupancy before the edge.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                    (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);

   assign wr_acc = write_enb_i && !full_o;
   assign rd_acc = read_enb_i && !empty_o;

   assign rd_tag  = mem_tag_q[rd_idx];
   assign rd_data = mem_data_q[rd_idx];

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      mem_tag_d = mem_tag_q;
      pkt_cnt_d = pkt_cnt_q;
      dout_d    = dout_q;
      oe_d      = oe_q;

      if (soft_reset_i) begin
         // Flush wins over any concurrent write or read.
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         mem_tag_d = '0;
         pkt_cnt_d = '0;
         oe_d      = 1'b0;
      end else begin
         if (wr_acc) begin
            mem_tag_d[wr_idx] = lfd_state_i;
            wr_ptr_d          = wr_ptr_q + PtrW'(1);
         end

         if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            dout_d   = rd_data;
            oe_d     = 1'b1;
            if (rd_tag) begin
               // Header carries payload length in bits 7:2; +1 covers parity.
               pkt_cnt_d = {1'b0, rd_data[7:2]} + 7'd1;
            end else if (pkt_cnt_q != 7'd0) begin
               pkt_cnt_d = pkt_cnt_q - 7'd1;
            end
         end else if (pkt_cnt_q == 7'd0) begin
            // Packet finished and port idle: release the output.
            oe_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         mem_tag_q <= '0;
         pkt_cnt_q <= '0;
         dout_q    <= '0;
         oe_q      <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         mem_tag_q <= mem_tag_d;
         pkt_cnt_q <= pkt_cnt_d;
         dout_q    <= dout_d;
         oe_q      <= oe_d;
      end
   end

   // Data array has no reset; stale contents are unreachable once pointers clear.
   always_ff @(posedge clk_i) begin
      if (!soft_reset_i && wr_acc) begin
         mem_data_q[wr_idx] <= data_in_i;
      end
   end

   assign data_out_o = oe_q ? dout_q : {WIDTH{1'bz}};

endmodule

// File: doc/router_fifo.md
# router_fifo

Per-destination output buffer of the 1x3 router. Sits directly downstream of the router register stage: it stores the bytes that stage drives on `dout`, and tags each packet's header byte using the FSM's `lfd_state`. It presents bytes to the destination port on request and tracks packet length on the read side. One instance exists per output port; the synchronizer drives `write_enb`, `soft_reset`, `full` and `empty` handling.

## Interface
- `DEPTH`, 16: number of entries; power of two, minimum 4.
- `WIDTH`, 8: data byte width; each entry stores WIDTH+1 bits, the extra bit being the header tag.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `soft_reset` input 1: synchronous, active-high; destination timeout flush from the synchronizer.
- `write_enb` input 1: write request.
- `read_enb` input 1: read request from the destination.
- `lfd_state` input 1: when high during an accepted write, marks that byte as a packet header.
- `data_in` input WIDTH: byte from the register stage `dout`.
- `data_out` output WIDTH: read data; driven to high-Z when no packet is in progress.
- `full` output 1: high when the FIFO holds DEPTH entries.
- `empty` output 1: high when the FIFO holds 0 entries.

## Operation
- Storage: DEPTH x (WIDTH+1) memory. Bit WIDTH is the header tag; bits WIDTH-1:0 are data.
- Pointers `wr_ptr` and `rd_ptr` are log2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - `empty` = pointers equal.
  - `full` = index bits equal and wrap bits differ.
  - Both are combinational from the registered pointers.
- Accepted write = `write_enb && !full`:
  - mem[wr_ptr index] <= {lfd_state, data_in}.
  - wr_ptr increments, wrapping modulo 2·DEPTH.
- Accepted read = `read_enb && !empty`:
  - `data_out` <= stored data bits.
  - rd_ptr increments.
- Packet counter `pkt_cnt` is 7 bits and is updated only on accepted reads:
  - Entry with tag = 1: `pkt_cnt` <= data[7:2] + 1. This is the payload length plus the parity byte.
  - Entry with tag = 0 and `pkt_cnt` != 0: `pkt_cnt` <= `pkt_cnt` − 1.
  - Entry with tag = 0 and `pkt_cnt` == 0: unchanged; the byte is still output.
- `data_out`:
  - Registered; updated only on accepted reads.
  - In a cycle without an accepted read and with `pkt_cnt` == 0, it becomes high-Z (all bits 'z') on the next edge.
  - Otherwise it holds its value.
- `full` and `empty` both reflect the pointer state at the start of the cycle (state before the edge). Consequences:
  - Write and read in the same cycle while full: the read proceeds and the write is dropped.
  - Write and read in the same cycle while empty: the write proceeds and the read is ignored.
  - Otherwise both proceed and the occupancy is unchanged.
- `soft_reset` (synchronous) at the edge:
  - Pointers, `pkt_cnt` and all memory tag bits go to 0.
  - `data_out` goes to high-Z.
  - `soft_reset` has priority over any write or read in the same cycle.
- `reset` (asynchronous) has the same effect as `soft_reset`, applied immediately without waiting for an edge. The data bits of memory entries need not be cleared.
- Reset values: `data_out` = high-Z, `full` = 0, `empty` = 1.

## Timing
- Write-to-`empty` deassert: `empty` falls the same cycle the write edge updates wr_ptr, i.e. one edge after `write_enb` is sampled.
- Read latency: 1 cycle. `data_out` is valid after the edge on which `read_enb` is sampled high with `empty` = 0.
- `full` asserts immediately after the edge that accepts the DEPTH-th write. It deasserts after the first accepted read.
- Header read:
  - `pkt_cnt` is loaded on the same edge as `data_out`.
  - For a header with length L, exactly L+1 further non-header reads bring `pkt_cnt` to 0.
  - `data_out` then goes high-Z on the first subsequent edge without an accepted read.
- Reset mid-packet: asynchronous clear. `empty` = 1 and `data_out` = high-Z within the same cycle, with no clock edge needed.
- Pointer wrap: after 2·DEPTH accepted writes, wr_ptr returns to 0. `full`/`empty` stay correct across the wrap.

## Test plan
- Reset and idle:
  - Assert `reset` asynchronously, between edges.
  - Required: `empty` = 1, `full` = 0, `data_out` = 8'hzz immediately, before the next edge.
- Single packet:
  - Write header 8'h0D with `lfd_state` = 1 (length 3, address 1), then 8'hA1, 8'hA2, 8'hA3 and parity 8'h?? with `lfd_state` = 0.
  - Read 5 bytes.
  - Required: the same 5 bytes in order, each one cycle after its read; `pkt_cnt` goes 4,3,2,1,0; `data_out` = z on the following idle cycle; `empty` = 1.
- Full boundary:
  - Write 16 bytes. Required: `full` = 1 after the 16th.
  - Write a 17th byte (8'hFF). Required: ignored.
  - Read 16 bytes. Required: the original 16 bytes with no 8'hFF; `empty` = 1.
- Simultaneous access:
  - With the FIFO full, assert `write_enb` and `read_enb` together. Required: one byte is read, the write is dropped, `full` = 0 afterwards.
  - With the FIFO empty, assert both together. Required: the write is accepted, `data_out` is unchanged, `empty` = 0 afterwards.
- Wrap-around:
  - Stream 40 bytes with interleaved read/write, keeping occupancy between 1 and 15.
  - Required: output order matches input order across pointer wrap; `full` and `empty` are never asserted spuriously.
- Soft reset mid-packet:
  - After reading the header and one payload byte of a length-5 packet, pulse `soft_reset` one cycle together with `write_enb`.
  - Required: `empty` = 1, `data_out` = z after the edge, and the concurrent write is discarded.
